// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch/jump flushes, mult/div EX occupancy
// and interrupt entry for the 5-stage core; drives PC/IF-ID/ID-EX/EX-MEM enables and flushes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal flow; hazard rules evaluated in priority order
//   MD_BUSY | mult/div holds EX; counts down, then one release cycle
//   IRQ     | vector fetched last cycle; acknowledge and clear pending
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] MemtoReg_ID_EX,
    input  logic [4:0] RegisterRt_ID_EX,
    input  logic [4:0] RegisterRs_IF_ID,
    input  logic [4:0] RegisterRt_IF_ID,
    input  logic       UsesRt_IF_ID,
    input  logic       BranchTaken_EX,
    input  logic       Jump_ID,
    input  logic       MdStart_EX,
    input  logic       Irq,
    input  logic       IrqEnable,
    output logic       PCWr,
    output logic       IF_ID_Wr,
    output logic       ID_EX_Wr,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       PCSel_Irq,
    output logic       IrqAck,
    output logic       MdBusy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        IRQ     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_dly_q, irq_dly_d;
    logic             irq_pend_q, irq_pend_d;
    logic             load_use;
    logic             irq_edge;

    assign load_use = (MemtoReg_ID_EX == 2'b01) && (RegisterRt_ID_EX != 5'd0) &&
                      ((RegisterRt_ID_EX == RegisterRs_IF_ID) ||
                       (UsesRt_IF_ID && (RegisterRt_ID_EX == RegisterRt_IF_ID)));

    assign irq_edge = Irq && !irq_dly_q && IrqEnable;

    always_comb begin
        PCWr         = 1'b1;
        IF_ID_Wr     = 1'b1;
        ID_EX_Wr     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        PCSel_Irq    = 1'b0;
        IrqAck       = 1'b0;
        MdBusy       = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        irq_dly_d    = Irq;
        irq_pend_d   = irq_pend_q;

        case (state_q)
            RUN: begin
                if (MdStart_EX) begin
                    PCWr         = 1'b0;
                    IF_ID_Wr     = 1'b0;
                    ID_EX_Wr     = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    MdBusy       = 1'b1;
                    cnt_d        = MD_LOAD;
                    state_d      = MD_BUSY;
                end else if (BranchTaken_EX) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    // Jump in ID is simply held and seen again once the bubble clears lu
                    PCWr        = 1'b0;
                    IF_ID_Wr    = 1'b0;
                    ID_EX_Flush = 1'b1;
                end else if (irq_pend_q) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    PCSel_Irq   = 1'b1;
                    state_d     = IRQ;
                end else if (Jump_ID) begin
                    IF_ID_Flush = 1'b1;
                end
            end
            MD_BUSY: begin
                MdBusy = 1'b1;
                if (cnt_q != '0) begin
                    PCWr         = 1'b0;
                    IF_ID_Wr     = 1'b0;
                    ID_EX_Wr     = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            IRQ: begin
                IrqAck     = 1'b1;
                irq_pend_d = 1'b0;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // A fresh edge outranks the clear issued by the IRQ state
        if (irq_edge) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            irq_dly_q  <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_dly_q  <= irq_dly_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule
